rpn_stack_engine: RTL

RPN_STACK_ENGINE -- requirements
Module: rpn_stack_engine

---
 rtl/rpn_pkg.sv | 21 ++
 rtl/rpn_stack_engine_if.sv | 28 ++
 rtl/rpn_seq_mult.sv | 65 ++++++
 rtl/rpn_stack_engine.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack engine: op codes, FSM states, reserved op range.
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_ADD  = 3'd2,
    OP_MLT  = 3'd3,
    OP_CLR  = 3'd4
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Codes 5..7 are accepted as no-ops that only clear the flags.
  localparam logic [2:0] OP_RSV_LO = 3'd5;
  localparam logic [2:0] OP_RSV_HI = 3'd7;

endpackage

// File: rtl/rpn_stack_engine_if.sv
// Operation request / stack status bundle between a host and rpn_stack_engine.
interface rpn_stack_engine_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned SW = $clog2(DEPTH + 1);

  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] din;
  logic             op_ready;
  logic [WIDTH-1:0] top;
  logic             top_valid;
  logic [SW-1:0]    size;
  logic [DEPTH-1:0] size_bar;
  logic             stk_oflw;
  logic             arith_oflw;

  modport master (
    output op_valid, op_code, din,
    input  op_ready, top, top_valid, size, size_bar, stk_oflw, arith_oflw
  );

  modport slave (
    input  op_valid, op_code, din,
    output op_ready, top, top_valid, size, size_bar, stk_oflw, arith_oflw
  );
endinterface

// File: rtl/rpn_seq_mult.sv
// Sequential signed multiplier: magnitude shift-add, one multiplier bit per cycle,
// sign applied at the end. Result and done are combinational on the final cycle.
module rpn_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic                    o_done_c,
  output logic [2*WIDTH-1:0]      o_prod_c,
  output logic                    o_oflw_c
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [PW-1:0] LIM_NEG = PW'({1'b1, {(WIDTH-1){1'b0}}});
  localparam logic [PW-1:0] LIM_POS = LIM_NEG - PW'(1);

  logic              r_busy;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_mcand;
  logic [WIDTH:0]    r_mplier;
  logic [PW-1:0]     r_acc;
  logic              r_neg;

  logic [WIDTH:0]    w_ext_a, w_ext_b, w_mag_a, w_mag_b;
  logic [PW-1:0]     w_acc_nxt;

  // Magnitudes in WIDTH+1 bits so the most negative operand stays exact.
  assign w_ext_a = {i_a[WIDTH-1], i_a};
  assign w_ext_b = {i_b[WIDTH-1], i_b};
  assign w_mag_a = i_a[WIDTH-1] ? (~w_ext_a + (WIDTH+1)'(1)) : w_ext_a;
  assign w_mag_b = i_b[WIDTH-1] ? (~w_ext_b + (WIDTH+1)'(1)) : w_ext_b;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done_c  = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_prod_c  = r_neg ? (PW'(0) - w_acc_nxt) : w_acc_nxt;
  assign o_oflw_c  = w_acc_nxt > (r_neg ? LIM_NEG : LIM_POS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (o_done_c) r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= PW'(w_mag_a);
      r_mplier <= w_mag_b;
      r_acc    <= '0;
      r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
    end
  end

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN stack calculator: PUSH/POP/ADD/MLT/CLR on a DEPTH-entry signed stack.
// Define RPN_SATURATE_EN to saturate overflowing ADD/MLT results instead of wrapping.
module rpn_stack_engine
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rpn_stack_engine_if.slave bus
);
  localparam int unsigned SW = $clog2(DEPTH + 1);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PW-1:0]    MAX_P = PW'(MAX_W);
  localparam logic [PW-1:0]    MIN_P = {{WIDTH{1'b1}}, MIN_W};
`ifdef RPN_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_e           r_state, w_state_nxt;
  logic             r_op_ready, w_op_ready_nxt;
  logic [WIDTH-1:0] r_stk [DEPTH];
  logic [WIDTH-1:0] w_stk_nxt [DEPTH];
  logic [WIDTH-1:0] w_stk_up [DEPTH];
  logic [WIDTH-1:0] w_stk_dn [DEPTH];
  logic [SW-1:0]    r_size, w_size_nxt;
  logic [DEPTH-1:0] r_size_bar, w_size_bar_nxt;
  logic             r_top_valid;
  logic             r_stk_oflw, w_stk_oflw_nxt;
  logic             r_arith_oflw, w_arith_oflw_nxt;

  logic             w_accept;
  logic             w_mult_start;
  logic             w_mult_done_c;
  logic [PW-1:0]    w_mult_prod_c;
  logic             w_mult_oflw_c;
  logic             w_prod_hi, w_prod_lo;
  logic [WIDTH-1:0] w_mult_fit;
  logic [WIDTH:0]   w_sum;
  logic             w_sum_oflw;
  logic [WIDTH-1:0] w_sum_fit;

  rpn_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_mult_start),
    .i_a      (r_stk[0]),
    .i_b      (r_stk[1]),
    .o_done_c (w_mult_done_c),
    .o_prod_c (w_mult_prod_c),
    .o_oflw_c (w_mult_oflw_c)
  );

  // Sum in WIDTH+1 bits; overflow when the two top bits disagree.
  assign w_sum      = {r_stk[0][WIDTH-1], r_stk[0]} + {r_stk[1][WIDTH-1], r_stk[1]};
  assign w_sum_oflw = w_sum[WIDTH] ^ w_sum[WIDTH-1];
  assign w_sum_fit  = (SAT_EN && w_sum_oflw) ? (w_sum[WIDTH] ? MIN_W : MAX_W)
                                             : w_sum[WIDTH-1:0];

  assign w_prod_hi  = $signed(w_mult_prod_c) > $signed(MAX_P);
  assign w_prod_lo  = $signed(w_mult_prod_c) < $signed(MIN_P);
  assign w_mult_fit = (SAT_EN && w_prod_hi) ? MAX_W :
                      (SAT_EN && w_prod_lo) ? MIN_W : w_mult_prod_c[WIDTH-1:0];

  // Shifted views of the stack used by push and by every shrinking op.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_stk_up[i] = (i == 0) ? '0 : r_stk[i-1];
      w_stk_dn[i] = (i + 1 < DEPTH) ? r_stk[i+1] : '0;
    end
  end

  assign w_accept = bus.op_valid && r_op_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_op_ready_nxt   = r_op_ready;
    w_stk_nxt        = r_stk;
    w_size_nxt       = r_size;
    w_stk_oflw_nxt   = r_stk_oflw;
    w_arith_oflw_nxt = r_arith_oflw;
    w_mult_start     = 1'b0;

    if (r_state == ST_BUSY) begin
      if (w_mult_done_c) begin
        w_stk_nxt        = w_stk_dn;
        w_stk_nxt[0]     = w_mult_fit;
        w_size_nxt       = r_size - SW'(1);
        w_arith_oflw_nxt = w_mult_oflw_c;
        w_state_nxt      = ST_IDLE;
        w_op_ready_nxt   = 1'b1;
      end
    end else if (w_accept) begin
      w_stk_oflw_nxt   = 1'b0;
      w_arith_oflw_nxt = 1'b0;
      case (bus.op_code)
        OP_PUSH: begin
          w_stk_nxt    = w_stk_up;
          w_stk_nxt[0] = bus.din;
          if (r_size == SW'(DEPTH)) w_stk_oflw_nxt = 1'b1;
          else                      w_size_nxt     = r_size + SW'(1);
        end
        OP_POP: begin
          if (r_size != '0) begin
            w_stk_nxt  = w_stk_dn;
            w_size_nxt = r_size - SW'(1);
          end
        end
        OP_ADD: begin
          if (r_size >= SW'(2)) begin
            w_stk_nxt        = w_stk_dn;
            w_stk_nxt[0]     = w_sum_fit;
            w_size_nxt       = r_size - SW'(1);
            w_arith_oflw_nxt = w_sum_oflw;
          end
        end
        OP_MLT: begin
          if (r_size >= SW'(2)) begin
            w_mult_start   = 1'b1;
            w_state_nxt    = ST_BUSY;
            w_op_ready_nxt = 1'b0;
          end else if (r_size == SW'(1)) begin
            w_stk_nxt[0] = '0;
          end
        end
        OP_CLR: begin
          for (int unsigned i = 0; i < DEPTH; i++) w_stk_nxt[i] = '0;
          w_size_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) w_size_bar_nxt[i] = (w_size_nxt > SW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op_ready   <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) r_stk[i] <= '0;
      r_size       <= '0;
      r_size_bar   <= '0;
      r_top_valid  <= 1'b0;
      r_stk_oflw   <= 1'b0;
      r_arith_oflw <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op_ready   <= w_op_ready_nxt;
      r_stk        <= w_stk_nxt;
      r_size       <= w_size_nxt;
      r_size_bar   <= w_size_bar_nxt;
      r_top_valid  <= (w_size_nxt != '0);
      r_stk_oflw   <= w_stk_oflw_nxt;
      r_arith_oflw <= w_arith_oflw_nxt;
    end
  end

  // Entries at or above size are always zero, so stack[0] already reads 0 when empty.
  assign bus.op_ready   = r_op_ready;
  assign bus.top        = r_stk[0];
  assign bus.top_valid  = r_top_valid;
  assign bus.size       = r_size;
  assign bus.size_bar   = r_size_bar;
  assign bus.stk_oflw   = r_stk_oflw;
  assign bus.arith_oflw = r_arith_oflw;

endmodule
